// File: rtl/ladner_fischer_exact.sv
// rtl/ladner_fischer_exact.sv - 16-bit exact Ladner-Fischer prefix adder with registered sum and carry vector
//
// Purpose: exact 16-bit adder with carry-in built on a Ladner-Fischer prefix
// carry network. This is the reference point for approximate prefix-adder variants.
// The prefix network is combinational. Sum and the full carry vector are
// captured in one register stage.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears Sum and Cout
//   A, B  [16:1] operands, bit 1 is the LSB
//   Cin   carry-in
//   Cout  [16:0] registered carries: Cout[0] = Cin, Cout[i] = carry out of bit i
//   Sum   [17:1] registered sum: Sum[16:1] sum bits, Sum[17] final carry-out

module ladner_fischer_exact (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:1] A,
    input  logic [16:1] B,
    input  logic        Cin,
    output logic [16:0] Cout,
    output logic [17:1] Sum
);

    logic [16:1] g;
    logic [16:1] p;

    // Per-level group generate/propagate. Index j is bit position i-1.
    logic [4:0][15:0] gv;
    logic [4:0][15:0] pv;

    logic [16:0] c;
    logic [17:1] s;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        gv = '0;
        pv = '0;
        gv[0] = g;
        pv[0] = p;
        // Folding Cin into the lowest generate makes every group that reaches
        // bit 1 carry the Cin contribution. No separate carry-in row is needed.
        gv[0][0] = g[1] | (p[1] & Cin);

        for (int k = 1; k <= 4; k++) begin
            gv[k] = gv[k-1];
            pv[k] = pv[k-1];
            for (int j = 0; j < 16; j++) begin
                if (((j >> (k - 1)) & 1) != 0) begin
                    // Combine with the top node of the lower half of this 2^k block.
                    gv[k][j] = gv[k-1][j] | (pv[k-1][j] & gv[k-1][((j >> (k - 1)) << (k - 1)) - 1]);
                    // Groups that reach bit 1 are complete carries (gray cell).
                    // Only the black cells above them need a group propagate.
                    if (j >= (1 << k)) begin
                        pv[k][j] = pv[k-1][j] & pv[k-1][((j >> (k - 1)) << (k - 1)) - 1];
                    end
                end
            end
        end

        c       = {gv[4], Cin};
        s[16:1] = p ^ c[15:0];
        s[17]   = c[16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum  <= '0;
            Cout <= '0;
        end else begin
            Sum  <= s;
            Cout <= c;
        end
    end

endmodule

// File: tb/tb_ladner_fischer_exact.sv
// tb/tb_ladner_fischer_exact.sv - self-checking bench for ladner_fischer_exact

module tb_ladner_fischer_exact;

    logic        clk;
    logic        rst;
    logic [16:1] a;
    logic [16:1] b;
    logic        cin;
    logic [16:0] cout;
    logic [17:1] sum;

    int checks;
    int errors;

    ladner_fischer_exact dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Cout (cout),
        .Sum  (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] sum;
        logic [16:0] cout;
    } vec_t;

    // Reference: plain integer arithmetic on the low i bits of each operand.
    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + int'(ci);
        return t[16:0];
    endfunction

    function automatic logic [16:0] ref_cout(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] r;
        int unsigned mask;
        int unsigned t;
        r[0] = ci;
        for (int i = 1; i <= 16; i++) begin
            mask = (32'd1 << i) - 32'd1;
            t = (int'(x) & mask) + (int'(y) & mask) + int'(ci);
            r[i] = ((t >> i) & 32'd1) != 0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [16:0] act_sum, input logic [16:0] exp_sum,
                         input logic [16:0] act_cout, input logic [16:0] exp_cout);
        checks++;
        if (act_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, act_sum, exp_sum);
        end
        checks++;
        if (act_cout !== exp_cout) begin
            errors++;
            $display("FAIL %s cout: got %h expected %h", name, act_cout, exp_cout);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = ci;
    endtask

    vec_t tbl[8];

    initial begin
        logic [15:0] ra, rb;
        logic        rc;

        checks = 0;
        errors = 0;

        tbl[0] = '{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 17'h00000};
        tbl[1] = '{16'hF0F0, 16'h0F0F, 1'b1, 17'h10000, 17'h1FFFF};
        tbl[2] = '{16'h0000, 16'hFFFF, 1'b0, 17'h0FFFF, 17'h00000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 17'h1FFFF};
        tbl[4] = '{16'h0001, 16'h0000, 1'b1, 17'h00002, 17'h00003};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 17'h10000};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 17'h00000};
        tbl[7] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000, 17'h1FFFF};

        // Asynchronous reset with nonzero operands, checked mid-cycle.
        rst = 1'b0;
        a   = 16'h1234;
        b   = 16'h4321;
        cin = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", sum, 17'h0, cout, 17'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", sum, 17'h0, cout, 17'h0);

        // First capture on the first rising edge after release.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_capture", sum, ref_sum(16'h1234, 16'h4321, 1'b1),
              cout, ref_cout(16'h1234, 16'h4321, 1'b1));

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin);
            @(posedge clk);
            #1;
            check($sformatf("table_%0d", i), sum, tbl[i].sum, cout, tbl[i].cout);
        end

        // Reset in the middle of a transaction discards the pending result.
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midop", sum, 17'h0, cout, 17'h0);
        drive(16'h7FFF, 16'h0001, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_midop", sum, 17'h08000, cout, 17'h0FFFE);

        // Back-to-back random vectors: one new vector per cycle.
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            @(posedge clk);
            #1;
            check($sformatf("random_%0d", i), sum, ref_sum(ra, rb, rc), cout, ref_cout(ra, rb, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
